// File: rtl/fetch_pkg.sv
// Shared RV32I fetch definitions: instruction width, default reset PC,
// fetch FSM state encodings and the buffer entry layout.
package fetch_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] addr);
        return {addr[ILEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, insn} pairs for decode.
// Flush empties it in one cycle and takes priority over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch.sv
// RV32I fetch stage: owns the PC, issues credit-limited in-order word reads,
// buffers responses for decode and flushes the stream on redirect.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [ILEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [ILEN-1:0] redirect_pc,
    output logic            insn_valid,
    input  logic            insn_ready,
    output logic [ILEN-1:0] insn,
    output logic [ILEN-1:0] insn_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [ILEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   stale_q, stale_d;

    logic [CW-1:0]   occupancy;
    logic [CW:0]     credits_used;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    head;
    fetch_entry_t    wentry;
    logic            req_fire;
    logic            rsp_ok;
    logic            push;
    logic            pop;
    logic            flush;

    // Every issued-but-undelivered word holds a credit until decode takes it.
    assign credits_used   = {1'b0, inflight_q} + {1'b0, occupancy};
    assign imem_req_valid = rst_n && (state_q == FETCH_RUN) && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign insn_valid = (state_q == FETCH_RUN) && !fifo_empty;
    assign insn       = insn_valid ? head.insn : '0;
    assign insn_pc    = insn_valid ? head.pc : '0;

    assign wentry = '{pc: rsp_pc_q, insn: imem_rsp_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH_RUN;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            stale_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
        end
    end

    // rsp_pc tracks the address of the next non-stale response, since
    // requests after a redirect are always sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        stale_d    = stale_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        rsp_ok     = 1'b0;
        unique case (state_q)
            FETCH_RUN: begin
                rsp_ok = imem_rsp_valid && (inflight_q != '0);
                if (redirect_valid) begin
                    flush      = 1'b1;
                    pc_d       = word_align(redirect_pc);
                    rsp_pc_d   = word_align(redirect_pc);
                    stale_d    = inflight_q + CW'(req_fire) - CW'(rsp_ok);
                    inflight_d = '0;
                    state_d    = (stale_d != '0) ? FETCH_FLUSH : FETCH_RUN;
                end else begin
                    push       = rsp_ok && !fifo_full;
                    pop        = insn_valid && insn_ready;
                    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
                    if (req_fire) begin
                        pc_d = pc_q + 32'd4;
                    end
                    if (rsp_ok) begin
                        rsp_pc_d = rsp_pc_q + 32'd4;
                    end
                end
            end
            FETCH_FLUSH: begin
                if (redirect_valid) begin
                    pc_d     = word_align(redirect_pc);
                    rsp_pc_d = word_align(redirect_pc);
                end
                if (imem_rsp_valid && (stale_q != '0)) begin
                    stale_d = stale_q - CW'(1);
                    if (stale_q == CW'(1)) begin
                        state_d = FETCH_RUN;
                    end
                end
            end
            default: state_d = FETCH_RUN;
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occupancy)
    );

    rsp_protocol_a: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((inflight_q != '0) || (stale_q != '0)));

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- RV32I instruction fetch stage; sits directly upstream of the instruction decoder and supplies it one 32-bit instruction word per handshake.
- Owns the program counter and issues in-order word reads to instruction memory over a valid/ready request channel; accepts responses in order on a valid-only channel.
- Buffers returned words in a small FIFO and presents them with their PC to decode.
- Supports a redirect (branch/jump/trap) that flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0.
- DEPTH, 2, instruction buffer entries; power of 2, ≥2; also the maximum number of requests in flight.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  word-aligned fetch address (bits [1:0] always 0).
- imem_rsp_valid  input  1  response word valid; one per accepted request, in order, latency ≥1 cycle.
- imem_rsp_data  input  32  response instruction word.
- redirect_valid  input  1  redirect the fetch stream this cycle.
- redirect_pc  input  32  new PC; bits [1:0] are ignored and forced to 0.
- insn_valid  output  1  instruction available to decode.
- insn_ready  input  1  decode consumes the instruction this cycle.
- insn  output  32  instruction word (head of buffer).
- insn_pc  output  32  address of insn.

Behaviour:
- Reset (rst_n=0 at an edge), applied regardless of any transaction in progress:
  - pc=RESET_PC, state=RUN, buffer empty, inflight=0, stale=0.
  - imem_req_valid=0, insn_valid=0, insn=0, insn_pc=0.
  - Responses arriving after reset are not expected; memory is reset together with this block.
- Credit rule, RUN state:
  - imem_req_valid=1 iff inflight + occupancy < DEPTH.
  - First request is asserted the first cycle after reset release; imem_req_addr=pc.
  - A request is accepted when valid && ready; on acceptance pc += 4 (wraps modulo 2^32) and inflight += 1.
- Request stability: while valid && !ready, addr holds. The request may be withdrawn or readdressed only in a redirect cycle.
- Response handling:
  - An imem_rsp_valid with stale=0 writes {data, pc_of_request} into the buffer and inflight -= 1.
  - The request PC is tracked by a PC FIFO of DEPTH entries, or equivalently by the buffer-tail PC plus 4.
- Output latency: a response captured at edge N makes insn_valid=1 in the cycle after edge N. No combinational path from imem_rsp_* to insn_*.
- Dequeue on insn_valid && insn_ready. insn and insn_pc are stable while insn_valid && !insn_ready.
- Simultaneous enqueue and dequeue on a full buffer is allowed only if credits permit; by construction, full implies inflight=0.
- State machine (RUN, FLUSH), redirect_valid=1 at an edge:
  - Buffer cleared.
  - pc=redirect_pc & ~3.
  - A request accepted in the same cycle is counted as stale.
  - stale = inflight (including that one); inflight=0.
  - A response arriving in the same cycle is discarded and decrements stale.
  - An insn handshake in the same cycle completes (decode owns that word); everything else is flushed.
  - Next state = FLUSH if resulting stale>0, else RUN.
- FLUSH state:
  - imem_req_valid=0 and insn_valid=0.
  - Each imem_rsp_valid is dropped and stale -= 1; when stale reaches 0 at an edge, next state=RUN.
  - A further redirect in FLUSH only reloads pc.
- Counter widths: inflight and stale are clog2(DEPTH)+1 bits. A response while inflight=0 and stale=0 is a protocol error; a simulation assertion flags it and the response is ignored.

Decomposition:
- Shared rv32i header: RESET_PC default, the state encodings FETCH_RUN/FETCH_FLUSH, and ILEN=32.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO (DEPTH × 64 bits for {pc, insn}) with push, pop, flush, full, empty and count.
- The credit, redirect and FSM logic stays in fetch.

Test Plan:
1. Reset release, imem_req_ready=1, 1-cycle latency memory returning addr+32'h13 → requests at 0x0, 0x4, 0x8…; insn_valid from the third cycle; insn_pc=0x0 with insn=0x13, then 0x4/0x17.
2. insn_ready=0 for 10 cycles → exactly DEPTH=2 requests issued, then imem_req_valid=0; insn and insn_pc held at 0x0 until ready rises, then stream resumes without loss.
3. 3-cycle latency memory, redirect_pc=0x103 while 2 requests are in flight → FLUSH for 3 cycles with both responses dropped; next request addr=0x100; first delivered insn_pc=0x100.
4. Redirect in the same cycle as a response and an insn handshake → handshake word is consumed by decode; response is discarded; no buffered word survives.
5. imem_req_ready=0 for 5 cycles → addr stable at 0x0; a redirect to 0x40 in cycle 3 readdresses the request to 0x40 with no stale count.
6. Redirect to 0xFFFF_FFFC → fetch addresses 0xFFFF_FFFC then 0x0000_0000 (wrap).
